// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle RV32I core: steps the shared datapath through fetch/decode/execute/memory/writeback.
// Latency: one state per cycle; memory states hold until mem_ready, or trap after MEM_TIMEOUT wait cycles.
// Backpressure: mem_req is held while mem_ready is low; an asynchronous reset drops it immediately.
module multicycle_control_fsm #(
    parameter logic RESET_VECTOR_SEL = 1'b0,
    parameter int   MEM_TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_sel,
    output logic       illegal_instr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_UPPER    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = (MEM_TIMEOUT < 1) ? '0 : CW'(MEM_TIMEOUT - 1);

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] to_cnt;
    logic          waiting;
    logic          timed_out;
    logic          br_taken;
    logic          br_bad;

    // funct7b5 is consumed by the ALU decoder when alu_op = 10, not by the sequencer
    logic unused_ok;
    assign unused_ok = &{1'b0, funct7b5};

    assign state     = cur;
    assign waiting   = ((cur == S_FETCH) || (cur == S_MEMREAD) || (cur == S_MEMWRITE)) && !mem_ready;
    // The wait that would bring the counter up to MEM_TIMEOUT traps instead
    assign timed_out = (MEM_TIMEOUT != 0) && waiting && (to_cnt == TO_LAST);
    assign br_bad    = (funct3 == 3'b010) || (funct3 == 3'b011);

    // Branch condition from the compare flags of rs1 - rs2
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = !alu_lt;
            3'b110:  br_taken = alu_ltu;
            3'b111:  br_taken = !alu_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-state selection
    always_comb begin
        nxt = cur;
        case (cur)
            S_RESET:  nxt = S_FETCH;
            S_FETCH:  nxt = mem_ready ? S_DECODE : (timed_out ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXECR;
                    OP_ITYPE:          nxt = S_EXECI;
                    OP_BRANCH:         nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR;
                    OP_LUI, OP_AUIPC:  nxt = S_UPPER;
                    default:           nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt = mem_ready ? S_MEMWB : (timed_out ? S_TRAP : S_MEMREAD);
            S_MEMWRITE: nxt = mem_ready ? S_FETCH : (timed_out ? S_TRAP : S_MEMWRITE);
            S_MEMWB:    nxt = S_FETCH;
            S_EXECR:    nxt = S_ALUWB;
            S_EXECI:    nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_BRANCH:   nxt = br_bad ? S_TRAP : S_FETCH;
            S_JAL:      nxt = S_ALUWB;
            S_JALR:     nxt = S_ALUWB;
            S_UPPER:    nxt = S_ALUWB;
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_TRAP;
        endcase
    end

    // State register, memory wait counter and sticky trap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur           <= S_RESET;
            to_cnt        <= '0;
            illegal_instr <= 1'b0;
        end else begin
            cur <= nxt;
            if (waiting && (nxt == cur)) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            if (nxt == S_TRAP) begin
                illegal_instr <= 1'b1;
            end
        end
    end

    // Datapath controls decoded from the current state
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        imm_sel    = 3'b000;
        case (cur)
            S_RESET: adr_src = RESET_VECTOR_SEL;
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = mem_ready;
                ir_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_sel   = 3'b010;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_sel   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                // JALR recomputes the link (old PC + 4) here and writes it straight from the ALU
                if (opcode == OP_JALR) begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                end
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = br_taken && !br_bad;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_JALR: begin
                pc_write   = 1'b1;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
            end
            S_UPPER: begin
                imm_sel   = 3'b011;
                alu_src_b = 2'b01;
                alu_src_a = (opcode == OP_LUI) ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

endmodule
